uart_baud_gen: RTL and testbench

Parametrised baud-rate generator for the UART transmit and receive paths. It generates the oversampled baud tick, the per-bit transmit tick and a mid-bit receive sample tick. The divisor has an integer part and an optional fractional part, and both are updated atomically at run time through a load strobe. It replaces the fixed 13-bit, 16x, table-driven fractional generator and drives the existing tx/rx shift logic unchanged.

---
 rtl/uart_baud_pkg.sv | 28 ++
 rtl/uart_baud_gen_if.sv | 31 +++
 rtl/uart_baud_frac_acc.sv | 41 ++++
 rtl/uart_baud_gen.sv | 108 ++++++++++
 tb/tb_uart_baud_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/uart_baud_pkg.sv
// Shared types, widths and legality checks for the UART baud generator.
package uart_baud_pkg;

   localparam int DIV_I_MAX = 32;
   localparam int DIV_F_MAX = 8;

   typedef struct packed {
      logic [DIV_I_MAX-1:0] i;
      logic [DIV_F_MAX-1:0] f;
   } div_pair_t;

   function automatic int phase_w(input int ovs);
      return $clog2(ovs);
   endfunction

   function automatic bit ovs_ok(input int ovs);
      return (ovs >= 4) && (ovs <= 64) && (ovs % 2 == 0);
   endfunction

   function automatic bit div_ok(input int cw, input int fw,
                                 input int di, input int df);
      return (cw >= 1) && (cw <= DIV_I_MAX) &&
             (fw >= 1) && (fw <= DIV_F_MAX) &&
             (di >= 0) && (longint'(di) < (longint'(1) << cw)) &&
             (df >= 0) && (longint'(df) < (longint'(1) << fw));
   endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle between the baud generator and the UART shifters.
interface uart_baud_gen_if
   import uart_baud_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int FRAC_W = 3,
   parameter int OVS    = 16
);

   localparam int PH_W = phase_w(OVS);

   logic              en;
   logic              load;
   logic [CNT_W-1:0]  baud_int;
   logic [FRAC_W-1:0] baud_frac;
   logic              baud_tick;
   logic              xmit_tick;
   logic              mid_tick;
   logic [PH_W-1:0]   ovs_phase;

   modport master (
      output en, load, baud_int, baud_frac,
      input  baud_tick, xmit_tick, mid_tick, ovs_phase
   );

   modport slave (
      input  en, load, baud_int, baud_frac,
      output baud_tick, xmit_tick, mid_tick, ovs_phase
   );

endinterface

// File: rtl/uart_baud_frac_acc.sv
// Fractional divisor accumulator: decides when a tick is stretched by a cycle.
module uart_baud_frac_acc #(
   parameter int FRAC_W   = 3,
   parameter int DEF_FRAC = 0
)(
   input  logic              clk,
   input  logic              aresetn,
   input  logic              en,
   input  logic              load,
   input  logic [FRAC_W-1:0] frac,
   input  logic              cnt_zero,
   output logic              stretch,
   output logic              hold
);

   logic [FRAC_W-1:0] div_f;
   logic [FRAC_W-1:0] acc;
   logic [FRAC_W:0]   sum;

   assign sum  = {1'b0, acc} + {1'b0, div_f};
   // carry out of the accumulator defers this tick by one cycle
   assign hold = !stretch && cnt_zero && sum[FRAC_W];

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         div_f   <= FRAC_W'(DEF_FRAC);
         acc     <= '0;
         stretch <= 1'b0;
      end else if (load) begin
         div_f   <= frac;
         acc     <= '0;
         stretch <= 1'b0;
      end else if (en && stretch) begin
         stretch <= 1'b0;
      end else if (en && cnt_zero) begin
         acc     <= sum[FRAC_W-1:0];
         stretch <= sum[FRAC_W];
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: oversample, bit-boundary and mid-bit ticks.
// Build option: define UART_BAUD_GEN_FRAC_EN for the fractional divisor.
module uart_baud_gen
   import uart_baud_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int FRAC_W   = 3,
   parameter int OVS      = 16,
   parameter int DEF_INT  = 0,
   parameter int DEF_FRAC = 0
)(
   input logic            clk,
   input logic            aresetn,
   uart_baud_gen_if.slave bus
);

   localparam int PH_W = phase_w(OVS);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);

   if (!ovs_ok(OVS)) begin : g_bad_ovs
      $error("uart_baud_gen: OVS must be even and within 4..64");
   end
   if (!div_ok(CNT_W, FRAC_W, DEF_INT, DEF_FRAC)) begin : g_bad_div
      $error("uart_baud_gen: divisor widths or defaults out of range");
   end

   div_pair_t        ld;
   logic             unused_ld;
   logic [CNT_W-1:0] div_i;
   logic [CNT_W-1:0] cnt;
   logic [PH_W-1:0]  phase;
   logic             cnt_zero;
   logic             stretch;
   logic             hold;
   logic             fire;
   logic             baud_q;
   logic             xmit_q;
   logic             mid_q;

   assign ld = '{i: DIV_I_MAX'(bus.baud_int),
                 f: DIV_F_MAX'(bus.baud_frac)};
   assign unused_ld = ^ld;
   assign cnt_zero  = (cnt == '0);

`ifdef UART_BAUD_GEN_FRAC_EN
   uart_baud_frac_acc #(
      .FRAC_W   (FRAC_W),
      .DEF_FRAC (DEF_FRAC)
   ) u_frac (
      .clk      (clk),
      .aresetn  (aresetn),
      .en       (bus.en),
      .load     (bus.load),
      .frac     (ld.f[FRAC_W-1:0]),
      .cnt_zero (cnt_zero),
      .stretch  (stretch),
      .hold     (hold)
   );
`else
   assign stretch = 1'b0;
   assign hold    = 1'b0;
`endif

   assign fire = bus.en && !bus.load &&
                 (stretch || (cnt_zero && !hold));

   // cnt parks at zero while a stretch cycle is pending
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         div_i <= CNT_W'(DEF_INT);
         cnt   <= CNT_W'(DEF_INT);
      end else if (bus.load) begin
         div_i <= ld.i[CNT_W-1:0];
         cnt   <= ld.i[CNT_W-1:0];
      end else if (fire) begin
         cnt   <= div_i;
      end else if (bus.en && !cnt_zero) begin
         cnt   <= cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         baud_q <= 1'b0;
         xmit_q <= 1'b0;
         mid_q  <= 1'b0;
         phase  <= '0;
      end else if (bus.load) begin
         baud_q <= 1'b0;
         xmit_q <= 1'b0;
         mid_q  <= 1'b0;
         phase  <= '0;
      end else begin
         baud_q <= fire;
         xmit_q <= fire && (phase == PH_LAST);
         mid_q  <= fire && (phase == PH_MID);
         if (fire)
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end
   end

   assign bus.baud_tick = baud_q;
   assign bus.xmit_tick = xmit_q;
   assign bus.mid_tick  = mid_q;
   assign bus.ovs_phase = phase;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: tick times, phase flags, en and reset.
module tb_uart_baud_gen;

   localparam int CNT_W    = 16;
   localparam int FRAC_W   = 3;
   localparam int OVS      = 16;
   localparam int DEF_INT  = 5;
   localparam int DEF_FRAC = 0;

   typedef struct {
      int e;
      bit x;
      bit m;
      int ph;
   } exp_t;

   logic clk = 1'b0;
   logic aresetn;

   always #5 clk = ~clk;

   uart_baud_gen_if #(
      .CNT_W  (CNT_W),
      .FRAC_W (FRAC_W),
      .OVS    (OVS)
   ) bus ();

   uart_baud_gen #(
      .CNT_W    (CNT_W),
      .FRAC_W   (FRAC_W),
      .OVS      (OVS),
      .DEF_INT  (DEF_INT),
      .DEF_FRAC (DEF_FRAC)
   ) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus.slave)
   );

   exp_t q[$];
   exp_t cur;
   int   total     = 0;
   int   bad       = 0;
   int   ecnt      = 0;
   bit   edge_en   = 1'b0;
   int   seg_base  = 0;
   int   exp_phase = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d ecnt=%0d", tag, got, exp, ecnt);
      end
   endtask

   // expected ticks counted in enabled clock edges from the segment base
   task automatic push_seg(input int base, input int di, input int df,
                           input int n);
      int acc;
      int e;
      int fe;
      int carry;
      acc = 0;
      e   = base;
`ifdef UART_BAUD_GEN_FRAC_EN
      fe = df;
`else
      fe = 0;
`endif
      q.delete();
      seg_base  = base;
      exp_phase = 0;
      for (int j = 0; j < n; j++) begin
         acc   = acc + fe;
         carry = (acc >= (1 << FRAC_W)) ? 1 : 0;
         acc   = acc % (1 << FRAC_W);
         e     = e + di + 1 + carry;
         q.push_back('{e, (j % OVS) == OVS - 1,
                       (j % OVS) == OVS / 2 - 1, (j + 1) % OVS});
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int di, input int df, input int n);
      bus.load      = 1'b1;
      bus.baud_int  = CNT_W'(di);
      bus.baud_frac = FRAC_W'(df);
      push_seg(ecnt + 1, di, df, n);
      step(1);
      bus.load = 1'b0;
   endtask

   always @(posedge clk) begin
      edge_en = aresetn && (bus.en || bus.load);
      if (edge_en)
         ecnt++;
   end

   always @(negedge clk) begin
      if (aresetn && q.size() > 0 && ecnt >= seg_base) begin
         if (edge_en && q[0].e == ecnt) begin
            cur = q.pop_front();
            chk("tick", 32'(bus.baud_tick), 32'd1);
            chk("xmit", 32'(bus.xmit_tick), 32'(cur.x));
            chk("mid", 32'(bus.mid_tick), 32'(cur.m));
            exp_phase = cur.ph;
         end else begin
            chk("no_tick", 32'(bus.baud_tick), 32'd0);
            chk("no_xmit", 32'(bus.xmit_tick), 32'd0);
            chk("no_mid", 32'(bus.mid_tick), 32'd0);
         end
         chk("phase", 32'(bus.ovs_phase), 32'(exp_phase));
      end
   end

   initial begin
      aresetn       = 1'b0;
      bus.en        = 1'b0;
      bus.load      = 1'b0;
      bus.baud_int  = '0;
      bus.baud_frac = '0;
      step(3);
      chk("rst_baud", 32'(bus.baud_tick), 32'd0);
      chk("rst_xmit", 32'(bus.xmit_tick), 32'd0);
      chk("rst_mid", 32'(bus.mid_tick), 32'd0);
      chk("rst_phase", 32'(bus.ovs_phase), 32'd0);

      aresetn = 1'b1;
      bus.en  = 1'b1;
      push_seg(ecnt, DEF_INT, DEF_FRAC, 5);
      step(32);
      chk("drain_def", q.size(), 0);

      do_load(3, 0, 40);
      step(164);
      chk("drain_div4", q.size(), 0);

      do_load(3, 4, 16);
      step(74);
      chk("drain_frac", q.size(), 0);

      do_load(0, 0, 40);
      step(42);
      chk("drain_div1", q.size(), 0);

      do_load(3, 0, 1);
      step(5);
      chk("drain_pre9", q.size(), 0);
      do_load(9, 0, 5);
      step(2);
      bus.baud_int = CNT_W'(2);
      step(50);
      chk("drain_noload", q.size(), 0);

      do_load(3, 0, 10);
      step(6);
      bus.en = 1'b0;
      step(10);
      bus.en = 1'b1;
      step(40);
      chk("drain_en", q.size(), 0);

      do_load(0, 0, 8);
      step(4);
      #2;
      chk("pre_rst_tick", 32'(bus.baud_tick), 32'd1);
      aresetn = 1'b0;
      q.delete();
      #1;
      chk("arst_baud", 32'(bus.baud_tick), 32'd0);
      chk("arst_xmit", 32'(bus.xmit_tick), 32'd0);
      chk("arst_mid", 32'(bus.mid_tick), 32'd0);
      chk("arst_phase", 32'(bus.ovs_phase), 32'd0);
      step(2);
      aresetn = 1'b1;
      push_seg(ecnt, DEF_INT, DEF_FRAC, 5);
      step(32);
      chk("drain_rel", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
